// File: rtl/kaiser_pkg.sv
// Shared definitions for the 16-bit pipelined core front end.
//   PC_W / IR_W   : program-counter and instruction widths
//   OP_*          : top-three-bit opcode values of an instruction word
//   fetch_state_t : fetch FSM states; HALT exists only when FETCH_HALT_EN is defined
//   fetch_entry_t : one fetched instruction together with its PC
// Optional feature macro: FETCH_HALT_EN.
package kaiser_pkg;

    localparam int unsigned PC_W = 8;
    localparam int unsigned IR_W = 16;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        FETCH,
        DROP
`ifdef FETCH_HALT_EN
        ,
        HALT
`endif
    } fetch_state_t;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch_entry_t between instruction fetch and decode.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears storage too)
//   flush       : synchronous discard of all entries
//   push, data  : enqueue request and entry (ignored when full)
//   pop         : dequeue head (ignored when empty)
//   head        : current head entry, straight from storage
//   count       : number of entries held
//   full, empty : occupancy flags
module fetch_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  kaiser_pkg::fetch_entry_t   data,
    input  logic                       pop,
    output kaiser_pkg::fetch_entry_t   head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    import kaiser_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/pipeline_f_fetch.sv
// Instruction fetch stage: sequential PC generation, single-outstanding
// req/ack reads from instruction memory, and a small queue feeding the
// stage-0 decoder through a valid/ready handshake. A redirect flushes the
// queue; an in-flight read at redirect time is drained and dropped.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   imem_req, imem_addr      : registered read request and address
//   imem_ack, imem_rdata     : read completion and data
//   redirect_valid/_pc       : taken-branch redirect pulse and target
//   out_valid/out_ready      : decoder handshake
//   IR_out, PC_out           : head instruction and its PC
//   halted                   : fetch stopped on a HALT word
// Optional feature macro: FETCH_HALT_EN (stop fetching after a HALT opcode;
// when undefined, halted is tied low and HALT words are ordinary).
// PC_W / IR_W must match the kaiser_pkg widths used by fetch_entry_t.
module pipeline_f_fetch #(
    parameter int unsigned         PC_W     = kaiser_pkg::PC_W,
    parameter int unsigned         IR_W     = kaiser_pkg::IR_W,
    parameter logic [PC_W-1:0]     RESET_PC = '0,
    parameter int unsigned         DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IR_W-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IR_W-1:0] IR_out,
    output logic [PC_W-1:0] PC_out,
    output logic            halted
);
    import kaiser_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t     state_q;
    logic             req_q;
    logic [PC_W-1:0]  addr_q;
    logic [PC_W-1:0]  fetch_pc_q;

    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic [CW-1:0]    q_count;
    logic [CW-1:0]    count_next;
    logic             q_full;
    logic             q_empty;

    logic             ack_fire;
    logic             push;
    logic             pop;
    logic             slot_free;
    logic             can_issue;
    logic             enter_halt;

    assign ack_fire   = req_q && imem_ack;
    assign pop        = !q_empty && out_ready;
    // Words acked in a redirect cycle or while draining a stale request are dropped.
    assign push       = ack_fire && (state_q == FETCH) && !redirect_valid && !q_full;
    assign push_entry = '{ir: imem_rdata, pc: addr_q};
    // No request outstanding after this edge unless we re-issue.
    assign slot_free  = !req_q || imem_ack;

    always_comb begin
        count_next = '0;
        if (!redirect_valid) begin
            count_next = q_count + CW'(push) - CW'(pop);
        end
    end

    // Only request when the returning word is guaranteed a free slot.
    assign can_issue = (count_next < CW'(DEPTH));

`ifdef FETCH_HALT_EN
    logic halted_q;
    assign enter_halt = push && (imem_rdata[IR_W-1 -: 3] == OP_HALT);
    assign halted     = halted_q;
`else
    assign enter_halt = 1'b0;
    assign halted     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
`ifdef FETCH_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
`ifdef FETCH_HALT_EN
            halted_q   <= 1'b0;
`endif
            if (req_q && !imem_ack) begin
                // Memory still owes us a word; keep the request up and drop it on ack.
                state_q <= DROP;
            end else begin
                state_q    <= FETCH;
                req_q      <= 1'b1;
                addr_q     <= redirect_pc;
                fetch_pc_q <= redirect_pc + 1'b1;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (slot_free) begin
                        if (can_issue && !enter_halt) begin
                            req_q      <= 1'b1;
                            addr_q     <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + 1'b1;
                        end else begin
                            req_q <= 1'b0;
                        end
                    end
`ifdef FETCH_HALT_EN
                    if (enter_halt) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
`endif
                end
                DROP: begin
                    if (ack_fire) begin
                        state_q <= FETCH;
                        if (can_issue) begin
                            req_q      <= 1'b1;
                            addr_q     <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + 1'b1;
                        end else begin
                            req_q <= 1'b0;
                        end
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    req_q <= 1'b0;
                end
`endif
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .data  (push_entry),
        .pop   (pop),
        .head  (head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_valid = !q_empty;
    assign IR_out    = head.ir;
    assign PC_out    = head.pc;

endmodule

// File: doc/pipeline_f_fetch.md
# pipeline_f_fetch

Instruction fetch stage for the 16-bit pipelined core. It generates sequential 8-bit PCs, runs a request/acknowledge handshake with instruction memory, and buffers returned words with their PCs in a 2-entry queue. The queue drives the stage-0 decoder's `IR_in`/`PC` inputs through a valid/ready handshake. Later stages can redirect fetch on a taken branch; the redirect flushes the queue and discards any in-flight word.

## Interface
- `PC_W`, 8, program-counter width
- `IR_W`, 16, instruction width
- `RESET_PC`, 8'h00, first fetch address after reset
- `DEPTH`, 2, output queue entries (power of two, ≥2)

Ports:
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — reset, asynchronous and active-low
- `imem_req` out 1 — read request, registered
- `imem_addr` out PC_W — read address, registered, stable while `imem_req` is high
- `imem_ack` in 1 — `imem_rdata` is valid this cycle; counts only while `imem_req` is high
- `imem_rdata` in IR_W — instruction word
- `redirect_valid` in 1 — one-cycle redirect pulse
- `redirect_pc` in PC_W — redirect target
- `out_valid` out 1 — queue head valid
- `out_ready` in 1 — decoder accepts head
- `IR_out` out IR_W — head instruction, feeds decoder `IR_in`
- `PC_out` out PC_W — head PC, feeds decoder `PC`
- `halted` out 1 — fetch stopped on HALT

## Operation
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC
  - `out_valid`=0, `IR_out`=0, `PC_out`=0
  - `halted`=0
  - state FETCH, `fetch_pc`=RESET_PC, queue empty
- State machine: FETCH, DROP, HALT.
- Transaction: completes on an edge where `imem_req && imem_ack`. At most one request is outstanding.
- Request rule:
  - `imem_req` is set at an edge when next state is FETCH and the next queue count (after this edge's push/pop) is below DEPTH.
  - At that edge, `imem_addr` = `fetch_pc` and `fetch_pc` increments.
  - Once asserted, `imem_req`/`imem_addr` hold until ack.
- FETCH, on a completed transaction: push {`imem_rdata`, `imem_addr`}. Back-to-back acks give one word per cycle.
- PC arithmetic: modulo 2^PC_W; 8'hFF is followed by 8'h00.
- Pop: when `out_valid && out_ready`. Push and pop in the same cycle are both performed, and count is unchanged. A push is never issued when the queue is full.
- Redirect (any state, at the edge):
  - Flush the queue and set `fetch_pc` = `redirect_pc`.
  - If a request is pending and not acked that cycle, go to DROP and keep the old request asserted.
  - Otherwise go to FETCH, with `imem_req`=1 and `imem_addr`=`redirect_pc` at that same edge; `fetch_pc` becomes `redirect_pc`+1.
  - A word acked in the redirect cycle is discarded.
  - A pop in the same cycle still completes; the flush takes effect after it.
- DROP:
  - On ack, discard the data and go to FETCH, issuing `fetch_pc` at that edge.
  - A redirect in DROP only updates `fetch_pc`; state stays DROP.

## Timing
- Ack in cycle t → `out_valid`=1 with that word in cycle t+1.
- Reset release → first `imem_req` at the first rising edge.
- Redirect in cycle t → `imem_addr`=`redirect_pc` from t+1 (no pending request), or from the edge after the dropped ack.
- `out_valid`, `IR_out` and `PC_out` come from registers/queue storage, with no combinational path from `imem_*`.
- Reset mid-transaction abandons the request; memory must tolerate `imem_req` dropping.

## Configuration
- `FETCH_HALT_EN` defined:
  - A pushed word with `IR[15:13]`==3'b111 is queued normally.
  - State then becomes HALT: no new requests, `halted`=1.
  - The queue continues to drain.
  - A redirect leaves HALT (to FETCH) and clears `halted`.
- `FETCH_HALT_EN` undefined: 3'b111 is an ordinary word, the HALT state is absent, and `halted` is tied 0.

## Structure
- Shared package `kaiser_pkg`:
  - `PC_W`/`IR_W` constants
  - opcode constants (OP_NOP 3'b000 … OP_HALT 3'b111)
  - `fetch_state_t` enum {FETCH, DROP, HALT}
  - `fetch_entry_t` struct {ir, pc}
- One sub-module, `fetch_queue`: DEPTH-entry FIFO of `fetch_entry_t` with push, pop, synchronous flush, count, full and empty.

## Test plan
- Reset, memory acks every cycle, `out_ready`=1 → `imem_addr` 00,01,02… each cycle; `PC_out` lags by one cycle; one word per cycle.
- `out_ready`=0 for 5 cycles → exactly 2 words queued, `imem_req` deasserts; raising `out_ready` gives PCs in order with no loss.
- Memory ack delayed 3 cycles, redirect to 8'h40 in the second wait cycle → old word discarded; next `imem_addr`=8'h40; first `PC_out`=8'h40.
- Redirect to 8'hFE, sequential run → PCs FE, FF, 00, 01.
- `FETCH_HALT_EN`, word 16'hE000 at PC 05 → word delivered with `PC_out`=05; `halted`=1; no further `imem_req`; redirect to 8'h10 resumes at 10.
- `rst_n` low mid-wait with 2 queued words → all outputs return to reset values immediately; fetch restarts at RESET_PC.
